// File: rtl/load_store_unit.sv
// Load/store unit: memory-stage bridge between the execute stage and a word-organised data
// memory. Accepts one request at a time, issues a word-aligned, byte-enabled access with a
// req/ack handshake, formats load data for write-back and stalls the pipeline while busy.
// Misaligned or illegal requests and memory timeouts complete with resp_err set.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake from/to the pipeline
//   req_we, req_op    1 = store / 0 = load, RV32I funct3
//   req_addr, wdata   byte address and store data (RS2)
//   resp_valid        one-cycle response pulse; resp_rdata/resp_err hold until the next one
//   stall             high whenever the unit is not idle
//   mem_req/we/addr/wdata/be   memory request, held stable until mem_ack or timeout
//   mem_ack, mem_rdata         memory completion; read data valid with ack
module load_store_unit #(
  parameter int unsigned WIDTH   = 32,  // only 32 is supported
  parameter int unsigned TIMEOUT = 16   // 1..255 cycles waiting for mem_ack
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  // funct3 encodings
  localparam logic [2:0] OpB  = 3'b000;
  localparam logic [2:0] OpH  = 3'b001;
  localparam logic [2:0] OpW  = 3'b010;
  localparam logic [2:0] OpBu = 3'b100;
  localparam logic [2:0] OpHu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e     state_q;
  logic [2:0] op_q;       // funct3 of the access in flight
  logic [1:0] lane_q;     // byte offset within the word
  logic       we_q;
  logic [7:0] cnt_q;      // cycles spent in StWait

  // ---------------------------------------------------------------------------------------------
  // Request decode helpers
  // ---------------------------------------------------------------------------------------------

  // Loads allow B/H/W/BU/HU; stores allow only B/H/W.
  function automatic logic is_illegal(input logic we, input logic [2:0] op);
    logic ill;
    if (we) begin
      ill = (op > OpW);
    end else begin
      ill = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
    end
    return ill;
  endfunction

  // Only meaningful for legal ops; op[1:0] distinguishes byte/half/word for loads and stores.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic mis;
    case (op[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across all lanes so the byte enables alone pick the target.
  function automatic logic [WIDTH-1:0] store_data(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] wdata);
    logic [WIDTH-1:0] d;
    case (op[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] load_format(input logic [2:0] op, input logic [1:0] lane,
                                                   input logic [WIDTH-1:0] word);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [WIDTH-1:0] d;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OpB:     d = {{24{b[7]}}, b};
      OpH:     d = {{16{h[15]}}, h};
      OpBu:    d = {24'b0, b};
      OpHu:    d = {16'b0, h};
      default: d = word;
    endcase
    return d;
  endfunction

  logic req_bad;
  assign req_bad = is_illegal(req_we, req_op) || is_misaligned(req_op, req_addr[1:0]);

  // ---------------------------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_q       <= 3'b000;
      lane_q     <= 2'b00;
      we_q       <= 1'b0;
      cnt_q      <= 8'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q   <= req_op;
            lane_q <= req_addr[1:0];
            we_q   <= req_we;
            cnt_q  <= 8'd0;
            if (req_bad) begin
              // Rejected requests never touch memory.
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state_q   <= StWait;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              mem_wdata <= store_data(req_op, req_wdata);
              mem_be    <= byte_enables(req_op, req_addr[1:0]);
            end
          end
        end

        StWait: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (mem_ack) begin
            state_q    <= StResp;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : load_format(op_q, lane_q, mem_rdata);
          end else if (cnt_q == TimeoutLast) begin
            state_q    <= StResp;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StResp: begin
          // mem_ack here (e.g. a late one after a timeout) is deliberately ignored.
          state_q    <= StIdle;
          resp_valid <= 1'b0;
        end

        default: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
        end
      endcase
    end
  end

  // Ready is gated by reset so it reads 0 while rst is held low.
  assign req_ready = rst && (state_q == StIdle);
  assign stall     = (state_q != StIdle);

  // ---------------------------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------------------------
  a_req_only_in_wait : assert property (@(posedge clk) disable iff (!rst)
    mem_req |-> (state_q == StWait));

  a_resp_single_pulse : assert property (@(posedge clk) disable iff (!rst)
    resp_valid |=> !resp_valid);

  a_mem_stable : assert property (@(posedge clk) disable iff (!rst)
    (mem_req && !mem_ack && (cnt_q != TimeoutLast)) |=>
      (mem_req && $stable(mem_addr) && $stable(mem_be) && $stable(mem_wdata) && $stable(mem_we)));

  a_op_legal_in_flight : assert property (@(posedge clk) disable iff (!rst)
    mem_req |-> !is_illegal(we_q, op_q));

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;        // cycles from accept edge to response, counting the accept cycle
    logic        access;     // a memory access is expected
    int          cycles;     // cycles mem_req stays high
    int          acc_before;
    int          accept_cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } memx_t;

  resp_t rq[$];
  memx_t mq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int acc_cnt = 0;
  int req_cycles = 0;
  int ack_delay = 0;
  logic [31:0] mem_word = 32'h0;
  logic late_ack = 1'b0;
  logic prev_req = 1'b0;
  logic [31:0] snap_addr, snap_wdata;
  logic [4:0]  snap_ctl;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model and response monitor (scoreboard side).
  always @(negedge clk) begin : mon
    resp_t r;
    memx_t m;
    if (resp_valid) begin
      if (rq.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        r = rq.pop_front();
        check({r.name, "_rdata"}, resp_rdata, r.rdata);
        check({r.name, "_err"}, 32'(resp_err), 32'(r.err));
        check({r.name, "_latency"}, 32'(cyc - r.accept_cyc + 1), 32'(r.lat));
        check({r.name, "_accesses"}, 32'(acc_cnt - r.acc_before), 32'(r.access));
        if (r.access) check({r.name, "_req_cycles"}, 32'(req_cycles), 32'(r.cycles));
      end
      resp_cnt++;
    end
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!prev_req) begin
        acc_cnt++;
        req_cycles = 0;
        snap_addr  = mem_addr;
        snap_wdata = mem_wdata;
        snap_ctl   = {mem_we, mem_be};
        if (mq.size() == 0) begin
          check("unexpected_mem_req", 32'(mem_req), 32'd0);
        end else begin
          m = mq.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_we", 32'(mem_we), 32'(m.we));
          check("mem_be", 32'(mem_be), 32'(m.be));
          if (m.chk_wdata) check("mem_wdata", mem_wdata, m.wdata);
        end
      end else begin
        check("mem_addr_stable", mem_addr, snap_addr);
        check("mem_ctl_stable", 32'({mem_we, mem_be}), 32'(snap_ctl));
        check("mem_wdata_stable", mem_wdata, snap_wdata);
      end
      if (req_cycles == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word;
      end
      req_cycles++;
    end else if (prev_req && late_ack) begin
      // Ack one cycle too late: must be ignored by the unit.
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
    end
    prev_req = mem_req;
  end

  // Issue one request at a negedge, then wait (bounded) for its response.
  task automatic issue(input string name, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mword, input int delay, input logic access,
                       input logic [31:0] eaddr, input logic [3:0] ebe,
                       input logic [31:0] ewdata, input logic [31:0] erdata,
                       input logic eerr, input int ecycles, input int elat);
    resp_t r;
    memx_t m;
    int    start;
    int    k;
    ack_delay = delay;
    mem_word  = mword;
    if (access) begin
      m.addr = eaddr; m.we = we; m.be = ebe; m.wdata = ewdata; m.chk_wdata = we;
      mq.push_back(m);
    end
    r.name = name; r.rdata = erdata; r.err = eerr; r.lat = elat; r.access = access;
    r.cycles = ecycles; r.acc_before = acc_cnt; r.accept_cyc = cyc + 1;
    rq.push_back(r);
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    start     = resp_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check({name, "_stall"}, 32'(stall), 32'd1);
    check({name, "_busy_ready"}, 32'(req_ready), 32'd0);
    k = 0;
    while (resp_cnt == start && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (resp_cnt == start) begin
      check({name, "_resp_timeout"}, 32'(resp_cnt), 32'(start + 1));
      rq.delete();
      mq.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    #1 rst = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    //     name      we    op      addr          wdata         mword        dly acc eaddr         be       ewdata        erdata        err cyc lat
    issue("lw",      1'b0, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'hDEAD_BEEF, 0, 1, 32'h10, 4'b1111, 32'h0,         32'hDEAD_BEEF, 0, 1, 2);
    issue("lb",      1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'h80FF_0000, 0, 1, 32'h10, 4'b1000, 32'h0,         32'hFFFF_FF80, 0, 1, 2);
    issue("lbu",     1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'h80FF_0000, 0, 1, 32'h10, 4'b1000, 32'h0,         32'h0000_0080, 0, 1, 2);
    issue("lhu",     1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h80FF_0000, 0, 1, 32'h10, 4'b1100, 32'h0,         32'h0000_80FF, 0, 1, 2);
    issue("lh_d2",   1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'h80FF_0000, 2, 1, 32'h10, 4'b1100, 32'h0,         32'hFFFF_80FF, 0, 3, 4);
    issue("lb_pos",  1'b0, 3'b000, 32'h0000_0011, 32'h0,         32'h0000_7F00, 0, 1, 32'h10, 4'b0010, 32'h0,         32'h0000_007F, 0, 1, 2);
    issue("sb",      1'b1, 3'b000, 32'h0000_0021, 32'h1234_56AB, 32'h5555_AAAA, 0, 1, 32'h20, 4'b0010, 32'hABAB_ABAB, 32'h0,         0, 1, 2);
    issue("sh",      1'b1, 3'b001, 32'h0000_0022, 32'h0000_CAFE, 32'h5555_AAAA, 0, 1, 32'h20, 4'b1100, 32'hCAFE_CAFE, 32'h0,         0, 1, 2);
    issue("sw_d1",   1'b1, 3'b010, 32'h0000_0024, 32'hA5A5_0F0F, 32'h5555_AAAA, 1, 1, 32'h24, 4'b1111, 32'hA5A5_0F0F, 32'h0,         0, 2, 3);
    issue("lw_mis",  1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         0, 0, 32'h0,  4'b0000, 32'h0,         32'h0,         1, 0, 1);
    issue("ld_ill",  1'b0, 3'b011, 32'h0000_0040, 32'h0,         32'h0,         0, 0, 32'h0,  4'b0000, 32'h0,         32'h0,         1, 0, 1);
    issue("st_ill",  1'b1, 3'b011, 32'h0000_0040, 32'h0,         32'h0,         0, 0, 32'h0,  4'b0000, 32'h0,         32'h0,         1, 0, 1);
    issue("sh_mis",  1'b1, 3'b001, 32'h0000_0023, 32'h0,         32'h0,         0, 0, 32'h0,  4'b0000, 32'h0,         32'h0,         1, 0, 1);
    issue("lhu_mis", 1'b0, 3'b101, 32'h0000_0041, 32'h0,         32'h0,         0, 0, 32'h0,  4'b0000, 32'h0,         32'h0,         1, 0, 1);
    // Ack on the last allowed cycle completes normally.
    issue("lw_edge", 1'b0, 3'b010, 32'h0000_0088, 32'h0,         32'h0BAD_F00D, 3, 1, 32'h88, 4'b1111, 32'h0,         32'h0BAD_F00D, 0, 4, 5);
    // No ack: timeout after TO cycles, then a late ack that must be ignored.
    late_ack = 1'b1;
    issue("lw_to",   1'b0, 3'b010, 32'h0000_0080, 32'h0,         32'h1111_1111, 255, 1, 32'h80, 4'b1111, 32'h0,       32'h0,         1, 4, 5);
    late_ack = 1'b0;
    issue("lw_after",1'b0, 3'b010, 32'h0000_0084, 32'h0,         32'h0123_4567, 0, 1, 32'h84, 4'b1111, 32'h0,         32'h0123_4567, 0, 1, 2);

    // Asynchronous reset in the middle of an access.
    begin : rst_mid
      memx_t m;
      m.addr = 32'h30; m.we = 1'b0; m.be = 4'b1111; m.wdata = 32'h0; m.chk_wdata = 1'b0;
      mq.push_back(m);
      ack_delay = 255;
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h30;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      check("wait_mem_req", 32'(mem_req), 32'd1);
      check("wait_stall", 32'(stall), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("arst_mem_req", 32'(mem_req), 32'd0);
      check("arst_stall", 32'(stall), 32'd0);
      check("arst_resp_valid", 32'(resp_valid), 32'd0);
      check("arst_req_ready", 32'(req_ready), 32'd0);
      check("arst_mem_be", 32'(mem_be), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rel_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    issue("sw_fresh",1'b1, 3'b010, 32'h0000_0050, 32'hCAFE_F00D, 32'h0,         0, 1, 32'h50, 4'b1111, 32'hCAFE_F00D, 32'h0,         0, 1, 2);

    repeat (3) @(negedge clk);
    #1;
    check("resp_queue_empty", 32'(rq.size()), 32'd0);
    check("mem_queue_empty", 32'(mq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
